boxhead_soc_multi_timer: RTL



---
 rtl/boxhead_timer_pkg.sv | 18 +
 rtl/boxhead_soc_multi_timer_if.sv | 15 +
 rtl/boxhead_soc_timer_channel.sv | 83 ++++++++
 rtl/boxhead_soc_multi_timer.sv | 83 ++++++++
 4 files changed

// File: rtl/boxhead_timer_pkg.sv
// Shared register map and bit positions for the Boxhead multi-channel timer.
package boxhead_timer_pkg;
    localparam logic [2:0] REG_STATUS   = 3'd0;
    localparam logic [2:0] REG_CONTROL  = 3'd1;
    localparam logic [2:0] REG_PERIOD_L = 3'd2;
    localparam logic [2:0] REG_PERIOD_H = 3'd3;
    localparam logic [2:0] REG_SNAP_L   = 3'd4;
    localparam logic [2:0] REG_SNAP_H   = 3'd5;
    localparam logic [2:0] REG_PRESCALE = 3'd6;
    localparam logic [2:0] REG_PENDING  = 3'd7;

    localparam int ST_TO    = 0;
    localparam int ST_RUN   = 1;
    localparam int CT_ITO   = 0;
    localparam int CT_CONT  = 1;
    localparam int CT_START = 2;
    localparam int CT_STOP  = 3;
endpackage

// File: rtl/boxhead_soc_multi_timer_if.sv
// Avalon-MM slave bus of the multi-channel timer; address is {channel, reg[2:0]}.
interface boxhead_soc_multi_timer_if #(
    parameter int NUM_CH = 4
);
    localparam int AW = $clog2(NUM_CH) + 3;

    logic [AW-1:0] address;
    logic          chipselect;
    logic          write_n;
    logic [15:0]   writedata;
    logic [15:0]   readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/boxhead_soc_timer_channel.sv
// One timer channel: prescaler, down-counter, period/snapshot/control registers and TO flag.
module boxhead_soc_timer_channel
    import boxhead_timer_pkg::*;
#(
    parameter int                CNT_W      = 32,
    parameter int                PRE_W      = 8,
    parameter logic [CNT_W-1:0]  RST_PERIOD = CNT_W'(49999)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr,
    input  logic [2:0]       reg_sel,
    input  logic [15:0]      wdata,
    output logic             run,
    output logic             to,
    output logic [3:0]       ctrl,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] snap,
    output logic [PRE_W-1:0] prescale
);
    logic [CNT_W-1:0] cnt;
    logic [PRE_W-1:0] pre_cnt;
    logic             force_reload;
    logic             cnt_nz_q;

    wire wr_stat   = wr && (reg_sel == REG_STATUS);
    wire wr_ctrl   = wr && (reg_sel == REG_CONTROL);
    wire wr_perl   = wr && (reg_sel == REG_PERIOD_L);
    wire wr_perh   = wr && (reg_sel == REG_PERIOD_H);
    wire wr_snap   = wr && (reg_sel == REG_SNAP_L || reg_sel == REG_SNAP_H);
    wire wr_pre    = wr && (reg_sel == REG_PRESCALE);
    wire start_w   = wr_ctrl && wdata[CT_START];
    wire stop_w    = wr_ctrl && wdata[CT_STOP];
    wire at_zero   = (cnt == '0);
    wire tick      = run && (pre_cnt == '0);
    // One-shot parks at zero: RUN drops and the counter is not reloaded.
    wire shot_done = run && !ctrl[CT_CONT] && at_zero;
    wire timeout   = at_zero && cnt_nz_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt          <= RST_PERIOD;
            period       <= RST_PERIOD;
            snap         <= '0;
            prescale     <= '0;
            pre_cnt      <= '0;
            ctrl         <= '0;
            run          <= 1'b0;
            to           <= 1'b0;
            force_reload <= 1'b0;
            cnt_nz_q     <= 1'b0;
        end else begin
            force_reload <= wr_perl || wr_perh;
            cnt_nz_q     <= !at_zero;
            if (wr_perl) period[15:0]       <= wdata;
            if (wr_perh) period[CNT_W-1:16] <= wdata[CNT_W-17:0];
            if (wr_ctrl) ctrl               <= wdata[3:0];
            if (wr_pre)  prescale           <= wdata[PRE_W-1:0];
            if (wr_snap) snap               <= cnt;

            if (force_reload)
                cnt <= period;
            else if (tick && !shot_done)
                cnt <= at_zero ? period : cnt - CNT_W'(1);

            if (force_reload || start_w)
                pre_cnt <= '0;
            else if (run)
                pre_cnt <= (pre_cnt == '0) ? prescale : pre_cnt - PRE_W'(1);

            if (start_w)
                run <= 1'b1;
            else if (stop_w || force_reload || shot_done)
                run <= 1'b0;

            // A timeout in the same cycle as a clear must not be lost.
            if (timeout)
                to <= 1'b1;
            else if (wr_stat)
                to <= 1'b0;
        end
    end
endmodule

// File: rtl/boxhead_soc_multi_timer.sv
// Multi-channel Avalon-MM interval timer: address decode, read mux, pending vector and combined irq.
module boxhead_soc_multi_timer
    import boxhead_timer_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 32,
    parameter int PRE_W      = 8,
    parameter int RST_PERIOD = 49999
) (
    input  logic                        clk,
    input  logic                        reset_n,
    boxhead_soc_multi_timer_if.slave    bus,
    output logic                        irq
);
    localparam int AW = $clog2(NUM_CH) + 3;

    logic [AW-1:0]                  ch_field;
    logic [2:0]                     reg_sel;
    logic                           wr_stb, rd_stb;
    logic [NUM_CH-1:0]              ch_hit;
    logic [NUM_CH-1:0]              run_v, to_v, ito_v;
    logic [NUM_CH-1:0][3:0]         ctrl_v;
    logic [NUM_CH-1:0][CNT_W-1:0]   period_v, snap_v;
    logic [NUM_CH-1:0][PRE_W-1:0]   pre_v;
    logic [15:0]                    rd_mux;

    assign ch_field = bus.address >> 3;
    assign reg_sel  = bus.address[2:0];
    assign wr_stb   = bus.chipselect && !bus.write_n;
    assign rd_stb   = bus.chipselect && bus.write_n;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign ch_hit[i] = (ch_field == AW'(i));
        assign ito_v[i]  = ctrl_v[i][CT_ITO];

        boxhead_soc_timer_channel #(
            .CNT_W      (CNT_W),
            .PRE_W      (PRE_W),
            .RST_PERIOD (CNT_W'(RST_PERIOD))
        ) u_ch (
            .clk      (clk),
            .reset_n  (reset_n),
            .wr       (wr_stb && ch_hit[i]),
            .reg_sel  (reg_sel),
            .wdata    (bus.writedata),
            .run      (run_v[i]),
            .to       (to_v[i]),
            .ctrl     (ctrl_v[i]),
            .period   (period_v[i]),
            .snap     (snap_v[i]),
            .prescale (pre_v[i])
        );
    end

    // Channel slots beyond NUM_CH never hit, so they read as zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_hit[i]) begin
                case (reg_sel)
                    REG_STATUS:   rd_mux = 16'({run_v[i], to_v[i]});
                    REG_CONTROL:  rd_mux = 16'(ctrl_v[i]);
                    REG_PERIOD_L: rd_mux = period_v[i][15:0];
                    REG_PERIOD_H: rd_mux = 16'(period_v[i][CNT_W-1:16]);
                    REG_SNAP_L:   rd_mux = snap_v[i][15:0];
                    REG_SNAP_H:   rd_mux = 16'(snap_v[i][CNT_W-1:16]);
                    REG_PRESCALE: rd_mux = 16'(pre_v[i]);
                    REG_PENDING:  rd_mux = 16'(to_v);
                    default:      rd_mux = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            bus.readdata <= '0;
        else
            bus.readdata <= rd_stb ? rd_mux : '0;
    end

    assign irq = |(to_v & ito_v);
endmodule
